butterfly_pipe: RTL and testbench

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

---
 rtl/butterfly_pkg.sv | 22 ++
 rtl/mod_mult.sv | 49 ++++
 rtl/butterfly_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// ---------------------------------------------------------------------------
// butterfly_pkg
// Shared definitions for the NTT butterfly pipeline.
//   W_DEF     : default coefficient / twiddle width
//   Q_DEF     : default prime modulus (odd, below 2^W_DEF)
//   CNT_W_DEF : default width of the completed-transaction counter
//   LAT       : edges from input acceptance to out_valid_o going high
//   mode_e    : butterfly flavour, Cooley-Tukey or Gentleman-Sande
// ---------------------------------------------------------------------------
package butterfly_pkg;

    localparam int unsigned W_DEF     = 23;
    localparam int unsigned Q_DEF     = 8380417;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned LAT       = 3;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } mode_e;

endpackage

// File: rtl/mod_mult.sv
// ---------------------------------------------------------------------------
// mod_mult
// Registered modular multiplier: p_o <= (x_i * y_i) mod Q.
// The result register only updates when en_i is high, so it freezes
// together with the rest of the pipeline during a downstream stall.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (clears the result)
//   en_i   : pipeline advance enable
//   x_i    : multiplicand, W bits
//   y_i    : multiplier (twiddle), W bits
//   p_o    : registered product modulo Q, W bits
// ---------------------------------------------------------------------------
module mod_mult
    import butterfly_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned Q = Q_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] p_o
);

    localparam logic [2*W-1:0] Q_WIDE = (2*W)'(Q);

    logic [2*W-1:0] prod;
    logic [W-1:0]   p_d;
    logic [W-1:0]   p_q;

    always_comb begin
        prod = {{W{1'b0}}, x_i} * {{W{1'b0}}, y_i};
        // The remainder is strictly below Q < 2^W, so truncation is lossless.
        p_d  = W'(prod % Q_WIDE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/butterfly_pipe.sv
// ---------------------------------------------------------------------------
// butterfly_pipe
// Pipelined modular NTT butterfly supporting Cooley-Tukey (forward) and
// Gentleman-Sande (inverse, optional scaling by 2^-1 mod Q).
// Structure: input register (operand capture, GS pre-add/sub, range check),
// then three stages: modular multiply, final add/sub, halving/output.
// One global advance enable freezes every register during a stall.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  : input handshake (in_ready_o = advance)
//   a_i, b_i, twiddle_i      : operands and twiddle
//   mode_i, half_i           : 0 = CT / 1 = GS, GS halving request
//   out_valid_o / out_ready_i: output handshake
//   a_o, b_o, err_o          : results and operand range error
//   done_cnt_o               : wrapping count of output transfers
// ---------------------------------------------------------------------------
module butterfly_pipe
    import butterfly_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned Q     = Q_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     twiddle_i,
    input  logic             mode_i,
    input  logic             half_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    output logic             err_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    localparam logic [W-1:0] Q_N = W'(Q);
    localparam logic [W:0]   Q_X = (W+1)'(Q);

    // (x + y) mod Q for x, y in [0, Q-1].
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_X) begin
            s = s - Q_X;
        end
        return s[W-1:0];
    endfunction

    // (x - y) mod Q for x, y in [0, Q-1].
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        if (x >= y) begin
            d = {1'b0, x} - {1'b0, y};
        end else begin
            d = {1'b0, x} + Q_X - {1'b0, y};
        end
        return d[W-1:0];
    endfunction

    // x * 2^-1 mod Q: Q is odd, so an odd x becomes even after adding Q.
    function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + Q_X) : {1'b0, x};
        return s[W:1];
    endfunction

    logic adv;

    // Input register
    mode_e        in_mode_d, in_mode_q;
    logic         in_vld_q;
    logic         in_half_d, in_half_q;
    logic         in_err_d, in_err_q;
    logic [W-1:0] in_x_d, in_x_q;
    logic [W-1:0] in_w_q;
    logic [W-1:0] in_side_d, in_side_q;

    // Stage 1: multiply (product lives inside mod_mult)
    logic [W-1:0] prod;
    mode_e        s1_mode_q;
    logic         s1_vld_q, s1_half_q, s1_err_q;
    logic [W-1:0] s1_side_q;

    // Stage 2: final add/sub
    logic         s2_vld_q, s2_half_q, s2_err_q;
    logic [W-1:0] s2_a_d, s2_b_d, s2_a_q, s2_b_q;

    // Stage 3: halving and output
    logic         out_vld_q, out_err_q;
    logic [W-1:0] out_a_d, out_b_d, out_a_q, out_b_q;

    logic [CNT_W-1:0] cnt_q;

    // Every register moves when the output is empty or being drained.
    assign adv        = out_ready_i | ~out_vld_q;
    assign in_ready_o = adv;

    always_comb begin
        in_mode_d = mode_e'(mode_i);
        // Halving only applies to GS; resolving it here keeps later stages simple.
        in_half_d = half_i & (in_mode_d == MODE_GS);
        in_err_d  = (a_i >= Q_N) | (b_i >= Q_N) | (twiddle_i >= Q_N);
        if (in_mode_d == MODE_GS) begin
            // GS multiplies the difference; the sum bypasses the multiplier.
            in_x_d    = sub_mod(a_i, b_i);
            in_side_d = add_mod(a_i, b_i);
        end else begin
            // CT multiplies b; a bypasses the multiplier.
            in_x_d    = b_i;
            in_side_d = a_i;
        end
    end

    mod_mult #(
        .W (W),
        .Q (Q)
    ) u_mod_mult (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (adv),
        .x_i    (in_x_q),
        .y_i    (in_w_q),
        .p_o    (prod)
    );

    always_comb begin
        if (s1_mode_q == MODE_GS) begin
            s2_a_d = s1_side_q;
            s2_b_d = prod;
        end else begin
            s2_a_d = add_mod(s1_side_q, prod);
            s2_b_d = sub_mod(s1_side_q, prod);
        end
    end

    always_comb begin
        out_a_d = s2_half_q ? half_mod(s2_a_q) : s2_a_q;
        out_b_d = s2_half_q ? half_mod(s2_b_q) : s2_b_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_vld_q  <= 1'b0;
            in_mode_q <= MODE_CT;
            in_half_q <= 1'b0;
            in_err_q  <= 1'b0;
            in_x_q    <= '0;
            in_w_q    <= '0;
            in_side_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_mode_q <= MODE_CT;
            s1_half_q <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_side_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_half_q <= 1'b0;
            s2_err_q  <= 1'b0;
            s2_a_q    <= '0;
            s2_b_q    <= '0;
            out_vld_q <= 1'b0;
            out_err_q <= 1'b0;
            out_a_q   <= '0;
            out_b_q   <= '0;
        end else if (adv) begin
            // A low in_valid_i loads a bubble that travels as an invalid stage.
            in_vld_q  <= in_valid_i;
            in_mode_q <= in_mode_d;
            in_half_q <= in_half_d;
            in_err_q  <= in_err_d;
            in_x_q    <= in_x_d;
            in_w_q    <= twiddle_i;
            in_side_q <= in_side_d;

            s1_vld_q  <= in_vld_q;
            s1_mode_q <= in_mode_q;
            s1_half_q <= in_half_q;
            s1_err_q  <= in_err_q;
            s1_side_q <= in_side_q;

            s2_vld_q  <= s1_vld_q;
            s2_half_q <= s1_half_q;
            s2_err_q  <= s1_err_q;
            s2_a_q    <= s2_a_d;
            s2_b_q    <= s2_b_d;

            out_vld_q <= s2_vld_q;
            out_err_q <= s2_err_q;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (out_vld_q && out_ready_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid_o = out_vld_q;
    assign err_o       = out_err_q;
    assign a_o         = out_a_q;
    assign b_o         = out_b_q;
    assign done_cnt_o  = cnt_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_butterfly_pipe
// Directed self-checking bench for butterfly_pipe with Q = 8380417.
// Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_butterfly_pipe;
    import butterfly_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [22:0] a         = '0;
    logic [22:0] b         = '0;
    logic [22:0] w         = '0;
    logic        mode      = 1'b0;
    logic        half      = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [22:0] ao;
    logic [22:0] bo;
    logic        err;
    logic [15:0] done_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    butterfly_pipe #(
        .W     (23),
        .Q     (8380417),
        .CNT_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .twiddle_i   (w),
        .mode_i      (mode),
        .half_i      (half),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .a_o         (ao),
        .b_o         (bo),
        .err_o       (err),
        .done_cnt_o  (done_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic [22:0] ta, input logic [22:0] tbv,
                            input logic [22:0] tw, input logic tm, input logic th);
        a = ta; b = tbv; w = tw; mode = tm; half = th; in_valid = 1'b1;
    endtask

    // Drive one transaction and advance to the cycle its result is visible.
    task automatic send_one(input logic [22:0] ta, input logic [22:0] tbv,
                            input logic [22:0] tw, input logic tm, input logic th);
        drive_in(ta, tbv, tw, tm, th);
        tick();
        in_valid = 1'b0;
        repeat (LAT) tick();
        $display("txn in=(%0d,%0d,%0d) mode=%0b half=%0b -> valid=%0b a_o=%0d b_o=%0d err=%0b",
                 ta, tbv, tw, tm, th, out_valid, ao, bo, err);
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
        checks++; if (ao !== 23'd0 || bo !== 23'd0) begin failures++; $display("FAIL reset_data got=%0d,%0d exp=0,0", ao, bo); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        repeat (4) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%0b exp=0", out_valid); end
    endtask

    task automatic test_ct();
        drive_in(23'd5, 23'd3, 23'd2, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ct_latency_early cycle=%0d got=%0b exp=0", k, out_valid); end
            tick();
        end
        $display("txn in=(5,3,2) mode=0 half=0 -> valid=%0b a_o=%0d b_o=%0d err=%0b", out_valid, ao, bo, err);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ct_latency got=%0b exp=1", out_valid); end
        checks++; if (ao !== 23'd11 || bo !== 23'd8380416 || err !== 1'b0) begin failures++; $display("FAIL ct_basic got=%0d,%0d,%0b exp=11,8380416,0", ao, bo, err); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ct_single_result got=%0b exp=0", out_valid); end

        send_one(23'd5, 23'd3, 23'd2, 1'b0, 1'b1);
        checks++; if (ao !== 23'd11 || bo !== 23'd8380416) begin failures++; $display("FAIL ct_half_ignored got=%0d,%0d exp=11,8380416", ao, bo); end
        tick();

        send_one(23'd8380416, 23'd8380416, 23'd8380416, 1'b0, 1'b0);
        checks++; if (ao !== 23'd0 || bo !== 23'd8380415 || err !== 1'b0) begin failures++; $display("FAIL ct_max_operands got=%0d,%0d,%0b exp=0,8380415,0", ao, bo, err); end
        tick();
    endtask

    task automatic test_gs();
        send_one(23'd10, 23'd4, 23'd3, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || ao !== 23'd14 || bo !== 23'd18) begin failures++; $display("FAIL gs_basic got=%0b,%0d,%0d exp=1,14,18", out_valid, ao, bo); end
        tick();
        send_one(23'd10, 23'd4, 23'd3, 1'b1, 1'b1);
        checks++; if (ao !== 23'd7 || bo !== 23'd9) begin failures++; $display("FAIL gs_half_even got=%0d,%0d exp=7,9", ao, bo); end
        tick();
        send_one(23'd1, 23'd0, 23'd1, 1'b1, 1'b1);
        checks++; if (ao !== 23'd4190209 || bo !== 23'd4190209) begin failures++; $display("FAIL gs_half_odd got=%0d,%0d exp=4190209,4190209", ao, bo); end
        tick();
        send_one(23'd0, 23'd1, 23'd2, 1'b1, 1'b0);
        checks++; if (ao !== 23'd1 || bo !== 23'd8380415) begin failures++; $display("FAIL gs_neg_diff got=%0d,%0d exp=1,8380415", ao, bo); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [22:0] ia [4];
        logic [22:0] ib [4];
        logic [22:0] iw [4];
        logic [22:0] ea [4];
        logic [22:0] eb [4];
        ia = '{23'd1, 23'd2, 23'd100, 23'd7};
        ib = '{23'd1, 23'd3, 23'd10,  23'd0};
        iw = '{23'd1, 23'd4, 23'd10,  23'd5};
        ea = '{23'd2, 23'd14, 23'd200, 23'd7};
        eb = '{23'd0, 23'd8380407, 23'd0, 23'd7};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_in(ia[i], ib[i], iw[i], 1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || ao !== ea[0] || bo !== eb[0]) begin failures++; $display("FAIL b2b_first got=%0b,%0d,%0d exp=1,%0d,%0d", out_valid, ao, bo, ea[0], eb[0]); end
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready cycle=%0d got=%0b exp=0", s, in_ready); end
            checks++; if (out_valid !== 1'b1 || ao !== ea[0] || bo !== eb[0]) begin failures++; $display("FAIL b2b_stall_hold cycle=%0d got=%0b,%0d,%0d exp=1,%0d,%0d", s, out_valid, ao, bo, ea[0], eb[0]); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            $display("txn b2b[%0d] -> valid=%0b a_o=%0d b_o=%0d err=%0b", i, out_valid, ao, bo, err);
            checks++; if (out_valid !== 1'b1 || ao !== ea[i] || bo !== eb[i]) begin failures++; $display("FAIL b2b_order idx=%0d got=%0b,%0d,%0d exp=1,%0d,%0d", i, out_valid, ao, bo, ea[i], eb[i]); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0b exp=0", out_valid); end
        checks++; if (done_cnt !== 16'd4) begin failures++; $display("FAIL b2b_done_cnt got=%0d exp=4", done_cnt); end
    endtask

    task automatic test_range_err();
        drive_in(23'd5, 23'd3, 23'd2, 1'b0, 1'b0);
        tick();
        drive_in(23'd8380417, 23'd1, 23'd1, 1'b0, 1'b0);
        tick();
        drive_in(23'd10, 23'd4, 23'd3, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        $display("txn err[0] -> valid=%0b a_o=%0d b_o=%0d err=%0b", out_valid, ao, bo, err);
        checks++; if (out_valid !== 1'b1 || ao !== 23'd11 || bo !== 23'd8380416 || err !== 1'b0) begin failures++; $display("FAIL err_before got=%0b,%0d,%0d,%0b exp=1,11,8380416,0", out_valid, ao, bo, err); end
        tick();
        $display("txn err[1] -> valid=%0b err=%0b", out_valid, err);
        checks++; if (out_valid !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL err_flag got=%0b,%0b exp=1,1", out_valid, err); end
        tick();
        $display("txn err[2] -> valid=%0b a_o=%0d b_o=%0d err=%0b", out_valid, ao, bo, err);
        checks++; if (out_valid !== 1'b1 || ao !== 23'd14 || bo !== 23'd18 || err !== 1'b0) begin failures++; $display("FAIL err_after got=%0b,%0d,%0d,%0b exp=1,14,18,0", out_valid, ao, bo, err); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL err_bubble got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        int stale;
        drive_in(23'd5, 23'd3, 23'd2, 1'b0, 1'b0);
        tick();
        drive_in(23'd10, 23'd4, 23'd3, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_precondition got=%0b exp=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b exp=0", out_valid); end
        checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL rst_async_cnt got=%0d exp=0", done_cnt); end
        checks++; if (ao !== 23'd0 || bo !== 23'd0 || err !== 1'b0) begin failures++; $display("FAIL rst_async_data got=%0d,%0d,%0b exp=0,0,0", ao, bo, err); end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0b exp=1", in_ready); end
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) stale++;
        end
        checks++; if (stale !== 0) begin failures++; $display("FAIL rst_stale_outputs got=%0d exp=0", stale); end
    endtask

    task automatic test_cnt_wrap();
        logic [15:0] exp_cnt;
        apply_reset();
        exp_cnt = 16'd0;
        drive_in(23'd1, 23'd1, 23'd1, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            if (exp_cnt == 16'hFFFF) break;
            if (out_valid === 1'b1) exp_cnt++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (exp_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_timeout got=%0d exp=65535", exp_cnt); end
        checks++; if (done_cnt !== exp_cnt) begin failures++; $display("FAIL wrap_preload got=%0d exp=%0d", done_cnt, exp_cnt); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%0b exp=1", out_valid); end
        tick();
        $display("txn wrap -> done_cnt=%0d", done_cnt);
        checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL wrap_to_zero got=%0d exp=0", done_cnt); end
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_ct();
        test_gs();
        test_back_to_back();
        test_range_err();
        test_reset_inflight();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
